// File: rtl/uart_status_tx_if.sv
// Handshake bundle between the capture registers and the status line sender.
// The master drives the request side and the slave drives the serial side.
interface uart_status_tx_if;
    logic       send;
    logic [1:0] count;
    logic [1:0] enable;
    logic       uart_tx;
    logic       busy;
    logic       done;

    modport master (
        output send,
        output count,
        output enable,
        input  uart_tx,
        input  busy,
        input  done
    );

    modport slave (
        input  send,
        input  count,
        input  enable,
        output uart_tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_status_tx.sv
// Sends the snapshot line "C=cc E=ee\r\n" as eleven 8N1 frames on uart_tx.
// Outputs are registered, so uart_tx falls on the edge that accepts send.
module uart_status_tx #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic             clk,
    input  logic             rst,
    uart_status_tx_if.slave  bus
);

    localparam int CW = $clog2(DELAY_FRAMES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] tick, tick_n;
    logic [3:0]    byte_idx, byte_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    cnt_lat, cnt_lat_n;
    logic [1:0]    en_lat, en_lat_n;
    logic          tx_q, tx_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic [7:0]    cur;
    logic          tick_end;

    assign tick_end = (tick == LAST);

    // Character currently on the wire, selected by the byte index.
    always_comb begin
        cur = 8'h0A;
        unique case (byte_idx)
            4'd0:    cur = 8'h43;
            4'd1:    cur = 8'h3D;
            4'd2:    cur = {7'b0011000, cnt_lat[1]};
            4'd3:    cur = {7'b0011000, cnt_lat[0]};
            4'd4:    cur = 8'h20;
            4'd5:    cur = 8'h45;
            4'd6:    cur = 8'h3D;
            4'd7:    cur = {7'b0011000, en_lat[1]};
            4'd8:    cur = {7'b0011000, en_lat[0]};
            4'd9:    cur = 8'h0D;
            default: cur = 8'h0A;
        endcase
    end

    // Next-state logic; tx_n is the level uart_tx takes at the coming edge.
    always_comb begin
        state_n   = state;
        tick_n    = tick;
        byte_n    = byte_idx;
        bit_n     = bit_idx;
        cnt_lat_n = cnt_lat;
        en_lat_n  = en_lat;
        tx_n      = 1'b1;
        busy_n    = busy_q;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.send) begin
                    state_n   = START;
                    cnt_lat_n = bus.count;
                    en_lat_n  = bus.enable;
                    byte_n    = 4'd0;
                    tick_n    = '0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (tick_end) begin
                    tick_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                    tx_n    = cur[0];
                end else begin
                    tick_n = tick + ONE;
                end
            end
            DATA: begin
                tx_n = cur[bit_idx];
                if (tick_end) begin
                    tick_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur[bit_idx + 3'd1];
                    end
                end else begin
                    tick_n = tick + ONE;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (tick_end) begin
                    tick_n = '0;
                    if (byte_idx == 4'd10) begin
                        state_n = IDLE;
                        byte_n  = 4'd0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        byte_n  = byte_idx + 4'd1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end
                end else begin
                    tick_n = tick + ONE;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any line in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            cnt_lat  <= 2'd0;
            en_lat   <= 2'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            byte_idx <= byte_n;
            bit_idx  <= bit_n;
            cnt_lat  <= cnt_lat_n;
            en_lat   <= en_lat_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.uart_tx = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
